// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and constants for the data-memory responder
package dmem_pkg;
    localparam int CNT_W = 4;
    localparam int WORD_BYTES = 4;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and registered read
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    // commit writes and capture reads on the access edge
    always_ff @(posedge clk_i) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder that stalls the pipeline until ack
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [AW-1:0]    idx_q, cur_idx;
    logic [31:0]      wdata_q, cur_data, rdata;
    logic             wr_q, err_q, zero_q;
    logic             req, err_in, idle, go, cur_wr, cur_err, we, re;
    assign req    = MemRead_i | MemWrite_i;
    assign err_in = (|addr_i[1:0]) | (addr_i >= 32'(WORD_BYTES * DEPTH_WORDS)) | (MemRead_i & MemWrite_i);
    assign idle   = state == IDLE;
    // with LATENCY==1 the access edge is the accept edge, so use live inputs in IDLE
    assign cur_idx  = idle ? addr_i[AW+1:2] : idx_q;
    assign cur_data = idle ? data_i : wdata_q;
    assign cur_wr   = idle ? MemWrite_i : wr_q;
    assign cur_err  = idle ? err_in : err_q;
    assign go = state_n == RESP;
    assign we = go & cur_wr & ~cur_err;
    assign re = go & ~cur_wr & ~cur_err;
    assign stall_o = (idle & req) | (state == BUSY);
    assign ack_o   = state == RESP;
    assign err_o   = ack_o & err_q;
    assign data_o  = zero_q ? 32'h0 : rdata;
    // state and counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // next state: accept in IDLE, count down in BUSY, single RESP cycle
    always_comb begin
        state_n = IDLE;
        cnt_n   = cnt;
        state_n = idle ? (req ? (LATENCY == 1 ? RESP : BUSY) : IDLE)
                : state == BUSY ? (cnt == CNT_W'(1) ? RESP : BUSY) : IDLE;
        cnt_n   = (idle & req) ? CNT_W'(LATENCY - 1) : state == BUSY ? cnt - CNT_W'(1) : cnt;
    end
    // latch the request on accept; data_o zeroing follows loads and errors only
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            if (idle & req) begin
                idx_q   <= addr_i[AW+1:2];
                wdata_q <= data_i;
                wr_q    <= MemWrite_i;
                err_q   <= err_in;
            end
            if (go & ~we) zero_q <= cur_err;
        end
    end
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
        .clk_i(clk_i),
        .we(we),
        .re(re),
        .addr(cur_idx),
        .wdata(cur_data),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for the data-memory responder
module tb_dmem_responder;
    localparam int LAT = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rd, wr, rd1, wr1;
    logic [31:0] addr, wd, rdo, addr1, wd1, rdo1;
    logic stall, ack, err, stall1, ack1, err1;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd), .MemWrite_i(wr),
        .addr_i(addr), .data_i(wd), .data_o(rdo), .stall_o(stall), .ack_o(ack), .err_o(err)
    );
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1),
        .addr_i(addr1), .data_i(wd1), .data_o(rdo1), .stall_o(stall1), .ack_o(ack1), .err_o(err1)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        e;
        logic        cd;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 want no ack at %0t", $time);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("resp_err", {31'b0, err}, {31'b0, x.e});
                if (x.cd) chk("resp_data", rdo, x.d);
            end
        end
    end

    task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee, input logic cd,
                       input logic chg, input logic [31:0] ca, input logic [31:0] cdat);
        @(posedge clk); #1;
        rd = r; wr = w; addr = a; wd = d;
        sb.push_back('{ed, ee, cd});
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk("busy_stall", {31'b0, stall}, 32'd1);
            chk("early_ack", {31'b0, ack}, 32'd0);
            if (i == 0 && chg) begin
                @(posedge clk); #1;
                addr = ca; wd = cdat;
            end
        end
        @(negedge clk);
        chk("ack_cycle", {31'b0, ack}, 32'd1);
        chk("resp_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rd = 0; wr = 0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] e);
        req(1, 0, a, 0, e, 0, 1, 0, 0, 0);
    endtask
    task automatic st(input logic [31:0] a, input logic [31:0] d);
        req(0, 1, a, d, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic bad(input logic r, input logic w, input logic [31:0] a);
        req(r, w, a, 32'h1111_1111, 0, 1, 1, 0, 0, 0);
    endtask

    initial begin
        rd = 0; wr = 0; addr = 0; wd = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_data", rdo, 32'd0);
        chk("rst_stall_idle", {31'b0, stall}, 32'd0);
        chk("rst_ack1", {31'b0, ack1}, 32'd0);
        rd = 1;
        #1 chk("rst_stall_req", {31'b0, stall}, 32'd1);
        rd = 0;
        @(posedge clk); #1 rst_n = 1;

        st(32'h10, 32'hDEAD_BEEF);
        ld(32'h10, 32'hDEAD_BEEF);
        repeat (2) begin
            @(negedge clk);
            chk("hold_data", rdo, 32'hDEAD_BEEF);
            chk("idle_stall", {31'b0, stall}, 32'd0);
        end
        bad(1, 0, 32'h12);
        bad(1, 0, 32'h400);
        bad(0, 1, 32'h11);
        bad(0, 1, 32'h410);
        bad(0, 1, 32'h8000_0010);
        bad(1, 1, 32'h10);
        ld(32'h10, 32'hDEAD_BEEF);
        st(32'h20, 32'h5);
        st(32'h34, 32'h7);

        @(posedge clk); #1;
        wr = 1; addr = 32'h20; wd = 32'hAAAA;
        @(negedge clk);
        chk("abort_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk);
        chk("abort_ack", {31'b0, ack}, 32'd0);
        chk("abort_data", rdo, 32'd0);
        @(posedge clk); #1 wr = 0;
        @(posedge clk); #1 rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_ack", {31'b0, ack}, 32'd0);
        end
        ld(32'h20, 32'h5);

        req(0, 1, 32'h30, 32'h1234, 0, 0, 0, 1, 32'h34, 32'hFFFF);
        ld(32'h30, 32'h1234);
        ld(32'h34, 32'h7);

        @(posedge clk); #1;
        wr1 = 1; addr1 = 32'h0; wd1 = 32'hCAFE;
        @(negedge clk);
        chk("l1_stall0", {31'b0, stall1}, 32'd1);
        chk("l1_ack0", {31'b0, ack1}, 32'd0);
        @(posedge clk); #1;
        wr1 = 0; rd1 = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("l1_ack", {31'b0, ack1}, {31'b0, k % 2 == 0});
            chk("l1_stall", {31'b0, stall1}, {31'b0, k % 2 != 0});
            if (k >= 2 && k % 2 == 0) begin
                chk("l1_data", rdo1, 32'hCAFE);
                chk("l1_err", {31'b0, err1}, 32'd0);
            end
        end
        @(posedge clk); #1 rd1 = 0;

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
